// File: rtl/jt6295_enc.sv
// OKI/MSM6295-compatible 4-bit ADPCM encoder; packs nibbles high-first into bytes.
// Optional macro JT6295_ENC_RESYNC_EN: servicing a flush also clears pred and idx.
`timescale 1ns/1ps
module jt6295_enc (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cen,
    input  logic signed [11:0] pcm_in,
    input  logic               pcm_valid,
    output logic               pcm_ready,
    input  logic               flush,
    output logic [7:0]         byte_dout,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               busy
);
    localparam int unsigned PCM_W   = 12;
    localparam int unsigned DIFF_W  = 13;
    localparam int unsigned STEP_W  = 11;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned SUM_W   = 14;
    localparam int unsigned IDX_MAX = 48;
    localparam logic signed [SUM_W-1:0] PRED_HI = 14'sd2047;
    localparam logic signed [SUM_W-1:0] PRED_LO = -14'sd2048;

    typedef enum logic [2:0] {IDLE, DIFF, Q2, Q1, Q0, UPD} state_t;

    function automatic logic [STEP_W-1:0] step_lut(input logic [IDX_W-1:0] i);
        case (i)
            6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
            6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
            6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
            6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
            6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
            6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
            6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
            6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
            6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
            6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
            6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
            6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
            6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
            6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
            6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
            6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
            default: step_lut = 11'd1552;
        endcase
    endfunction

    function automatic logic signed [7:0] idx_adj(input logic [2:0] m);
        case (m)
            3'd4:    idx_adj = 8'sd2;
            3'd5:    idx_adj = 8'sd4;
            3'd6:    idx_adj = 8'sd6;
            3'd7:    idx_adj = 8'sd8;
            default: idx_adj = -8'sd1;
        endcase
    endfunction

    state_t                    state;
    logic signed [PCM_W-1:0]   x;
    logic signed [PCM_W-1:0]   pred;
    logic [IDX_W-1:0]          idx;
    logic [STEP_W-1:0]         step;
    logic [DIFF_W-1:0]         d;
    logic [3:0]                n;
    logic [3:0]                hi;
    logic                      half;
    logic                      flush_pend;

    logic signed [DIFF_W-1:0]  diff;
    logic [DIFF_W-1:0]         d_abs;
    logic [DIFF_W-1:0]         step2, step1, step0;
    logic [PCM_W-1:0]          delta;
    logic signed [SUM_W-1:0]   pred_sum;
    logic signed [PCM_W-1:0]   pred_sat;
    logic signed [7:0]         idx_sum;
    logic [IDX_W-1:0]          idx_clamp;
    logic                      svc;
    logic                      accept;

    // Datapath for the quantiser and the predictor/index update
    always_comb begin
        diff     = DIFF_W'(x) - DIFF_W'(pred);
        d_abs    = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
        step2    = DIFF_W'(step);
        step1    = DIFF_W'(step >> 1);
        step0    = DIFF_W'(step >> 2);
        delta    = PCM_W'(step >> 3)
                 + (n[2] ? PCM_W'(step)      : '0)
                 + (n[1] ? PCM_W'(step >> 1) : '0)
                 + (n[0] ? PCM_W'(step >> 2) : '0);
        pred_sum = n[3] ? SUM_W'(pred) - $signed(SUM_W'(delta))
                        : SUM_W'(pred) + $signed(SUM_W'(delta));
        if (pred_sum > PRED_HI)      pred_sat = PCM_W'(PRED_HI);
        else if (pred_sum < PRED_LO) pred_sat = PCM_W'(PRED_LO);
        else                         pred_sat = PCM_W'(pred_sum);
        idx_sum = $signed({2'b00, idx}) + idx_adj(n[2:0]);
        if (idx_sum < 8'sd0)       idx_clamp = '0;
        else if (idx_sum > 8'sd48) idx_clamp = IDX_W'(IDX_MAX);
        else                       idx_clamp = IDX_W'(idx_sum);
    end

    // A flush arriving this cycle already blocks the sample so it is serviced first
    assign svc       = (flush | flush_pend) & (state == IDLE) & ~byte_valid;
    assign pcm_ready = (state == IDLE) & ~byte_valid & ~flush_pend & ~flush;
    assign accept    = cen & pcm_valid & pcm_ready;
    assign busy      = (state != IDLE) | half | flush_pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            x          <= '0;
            pred       <= '0;
            idx        <= '0;
            step       <= '0;
            d          <= '0;
            n          <= '0;
            hi         <= '0;
            half       <= 1'b0;
            flush_pend <= 1'b0;
            byte_dout  <= '0;
            byte_valid <= 1'b0;
        end else begin
            if (byte_valid && byte_ready) byte_valid <= 1'b0;

            if (svc) begin
                flush_pend <= 1'b0;
                if (half) begin
                    byte_dout  <= {hi, 4'h0};
                    byte_valid <= 1'b1;
                    half       <= 1'b0;
                end
`ifdef JT6295_ENC_RESYNC_EN
                pred <= '0;
                idx  <= '0;
`endif
            end else if (flush) begin
                flush_pend <= 1'b1;
            end

            if (cen) begin
                case (state)
                    IDLE: if (accept) begin
                        x     <= pcm_in;
                        state <= DIFF;
                    end
                    DIFF: begin
                        step  <= step_lut(idx);
                        n     <= {diff[DIFF_W-1], 3'b000};
                        d     <= d_abs;
                        state <= Q2;
                    end
                    Q2: begin
                        if (d >= step2) begin
                            n[2] <= 1'b1;
                            d    <= d - step2;
                        end
                        state <= Q1;
                    end
                    Q1: begin
                        if (d >= step1) begin
                            n[1] <= 1'b1;
                            d    <= d - step1;
                        end
                        state <= Q0;
                    end
                    Q0: begin
                        n[0]  <= (d >= step0);
                        state <= UPD;
                    end
                    UPD: begin
                        pred <= pred_sat;
                        idx  <= idx_clamp;
                        if (half) begin
                            byte_dout  <= {hi, n};
                            byte_valid <= 1'b1;
                            half       <= 1'b0;
                        end else begin
                            hi   <= n;
                            half <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jt6295_enc.sv
// Self-checking bench for jt6295_enc: vector table, scoreboard model, corner sequences.
`timescale 1ns/1ps
module tb_jt6295_enc;
    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               cen = 1'b1;
    logic signed [11:0] pcm_in = '0;
    logic               pcm_valid = 1'b0;
    logic               pcm_ready;
    logic               flush = 1'b0;
    logic [7:0]         byte_dout;
    logic               byte_valid;
    logic               byte_ready = 1'b1;
    logic               busy;

    always #5 clk = ~clk;

    jt6295_enc dut (
        .clk(clk), .rstn(rstn), .cen(cen), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .flush(flush), .byte_dout(byte_dout),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy)
    );

`ifdef JT6295_ENC_RESYNC_EN
    localparam logic [7:0] RESYNC_EXP = 8'h07;
`else
    localparam logic [7:0] RESYNC_EXP = 8'hB7;
`endif

    typedef struct {
        int         a;
        int         b;
        logic [7:0] exp;
    } vec_t;

    int step_tbl [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,
                          118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,
                          544,598,658,724,796,876,963,1060,1166,1282,1411,1552};
    int adj_tbl [8] = '{-1,-1,-1,-1,2,4,6,8};

    int         checks = 0;
    int         errors = 0;
    int         m_pred, m_idx;
    bit         m_half;
    logic [3:0] m_hi;
    logic [7:0] exp_q [$];
    logic [7:0] last_byte = '0;
    int         rx_count = 0;
    bit         rand_mode = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pred = 0; m_idx = 0; m_half = 1'b0; m_hi = '0;
        exp_q.delete();
    endtask

    task automatic model_sample(input int xs);
        int st, dd, nib, delta;
        st = step_tbl[m_idx];
        dd = xs - m_pred;
        nib = 0;
        if (dd < 0) begin nib = 8; dd = -dd; end
        if (dd >= st)     begin nib += 4; dd -= st; end
        if (dd >= st / 2) begin nib += 2; dd -= st / 2; end
        if (dd >= st / 4) nib += 1;
        delta = st / 8;
        if ((nib & 4) != 0) delta += st;
        if ((nib & 2) != 0) delta += st / 2;
        if ((nib & 1) != 0) delta += st / 4;
        m_pred = (nib >= 8) ? m_pred - delta : m_pred + delta;
        if (m_pred > 2047)  m_pred = 2047;
        if (m_pred < -2048) m_pred = -2048;
        m_idx += adj_tbl[nib & 7];
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 48) m_idx = 48;
        if (m_half) begin
            exp_q.push_back({m_hi, 4'(nib)});
            m_half = 1'b0;
        end else begin
            m_hi = 4'(nib);
            m_half = 1'b1;
        end
    endtask

    task automatic model_flush();
        if (m_half) begin
            exp_q.push_back({m_hi, 4'h0});
            m_half = 1'b0;
        end
`ifdef JT6295_ENC_RESYNC_EN
        m_pred = 0;
        m_idx = 0;
`endif
    endtask

    // Scoreboard: push on accepted stimulus, pop on byte handshake
    always @(negedge clk) begin
        if (rstn) begin
            if (cen && pcm_valid && pcm_ready) model_sample(int'(pcm_in));
            if (flush) model_flush();
            if (byte_valid && byte_ready) begin
                last_byte = byte_dout;
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_unexpected: got 0x%02h expected no byte", byte_dout);
                end else begin
                    chk("byte_out", int'(byte_dout), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            cen = ($urandom_range(0, 3) != 0);
            byte_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic do_reset();
        rand_mode = 1'b0;
        rstn = 1'b0; pcm_valid = 1'b0; flush = 1'b0; byte_ready = 1'b1; cen = 1'b1;
        repeat (2) step_clk();
        model_reset();
        rx_count = 0;
        rstn = 1'b1;
        step_clk();
    endtask

    task automatic send(input int v);
        bit acc;
        acc = 1'b0;
        pcm_in = 12'(v);
        pcm_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            acc = pcm_ready && cen;
            step_clk();
            if (acc) break;
        end
        pcm_valid = 1'b0;
        if (!acc) chk("send_accept_timeout", 0, 1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step_clk();
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy && !byte_valid;
            step_clk();
            if (done) break;
        end
        chk(name, int'(done), 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [6];
        bit   got;
        tv[0] = '{0,     1000,  8'h07};
        tv[1] = '{-1000, 0,     8'hF3};
        tv[2] = '{0,     0,     8'h08};
        tv[3] = '{1000,  1000,  8'h77};
        tv[4] = '{-1000, -1000, 8'hFF};
        tv[5] = '{5,     -5,    8'h1A};

        do_reset();
        @(negedge clk);
        chk("rst_pcm_ready", int'(pcm_ready), 1);
        chk("rst_byte_valid", int'(byte_valid), 0);
        chk("rst_byte_dout", int'(byte_dout), 0);
        chk("rst_busy", int'(busy), 0);
        step_clk();

        for (int i = 0; i < 6; i++) begin
            do_reset();
            send(tv[i].a);
            send(tv[i].b);
            drain($sformatf("vec%0d_drain", i));
            chk($sformatf("vec%0d_byte", i), int'(last_byte), int'(tv[i].exp));
            chk($sformatf("vec%0d_count", i), rx_count, 1);
        end

        // Flush with a half byte pending pads it; without one, nothing is emitted
        do_reset();
        send(1000);
        do_flush();
        drain("flush_drain");
        chk("flush_byte", int'(last_byte), 8'h70);
        chk("flush_busy", int'(busy), 0);
        send(0);
        send(0);
        drain("flush_pair_drain");
        do_flush();
        repeat (4) step_clk();
        chk("flush_nohalf_count", rx_count, 2);
        chk("flush_nohalf_busy", int'(busy), 0);

        // Flush and sample in the same idle cycle, then phrase restart
        do_reset();
        send(1000);
        repeat (8) step_clk();
        pcm_in = 12'(0);
        pcm_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_first_ready", int'(pcm_ready), 0);
        step_clk();
        flush = 1'b0;
        send(0);
        send(1000);
        drain("resync_drain");
        chk("resync_count", rx_count, 2);
        chk("resync_byte", int'(last_byte), int'(RESYNC_EXP));

        // Backpressure: byte held stable, no sample accepted until released
        do_reset();
        byte_ready = 1'b0;
        send(0);
        send(1000);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            got = byte_valid;
            step_clk();
            if (got) break;
        end
        chk("stall_byte_arrives", int'(got), 1);
        pcm_in = 12'(-1000);
        pcm_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(byte_valid), 1);
            chk("stall_data", int'(byte_dout), 8'h07);
            chk("stall_ready", int'(pcm_ready), 0);
            step_clk();
        end
        byte_ready = 1'b1;
        send(-1000);
        send(0);
        drain("stall_drain");
        chk("stall_count", rx_count, 2);
        chk("stall_after", int'(last_byte), 8'hF1);

        // Saturation at both rails
        do_reset();
        repeat (200) send(2047);
        drain("sat_pos_drain");
        repeat (200) send(-2048);
        drain("sat_neg_drain");
        chk("sat_count", rx_count, 200);

        // Random samples with random cen, backpressure and flushes
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(int'($urandom_range(0, 4095)) - 2048);
            if ($urandom_range(0, 15) == 0) do_flush();
        end
        do_flush();
        drain("rand_drain");
        rand_mode = 1'b0;
        cen = 1'b1;
        byte_ready = 1'b1;

        // Asynchronous reset with a byte and a flush pending
        do_reset();
        byte_ready = 1'b0;
        send(0);
        send(1000);
        repeat (8) step_clk();
        do_flush();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_byte_valid", int'(byte_valid), 0);
        chk("async_busy", int'(busy), 0);
        model_reset();
        rx_count = 0;
        byte_ready = 1'b1;
        step_clk();
        rstn = 1'b1;
        step_clk();
        send(5);
        send(-5);
        drain("async_after_drain");
        chk("async_after_byte", int'(last_byte), 8'h1A);

        // Asynchronous reset with a sample in flight and a half byte held
        do_reset();
        send(1000);
        send(-1000);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("inflight_busy", int'(busy), 0);
        model_reset();
        rx_count = 0;
        step_clk();
        rstn = 1'b1;
        step_clk();
        send(0);
        send(1000);
        drain("inflight_drain");
        chk("inflight_byte", int'(last_byte), 8'h07);
        chk("inflight_count", rx_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
